// File: rtl/che_hist_ctrl_if.sv
// Pixel-side and histogram-store-side signal bundle for che_hist_ctrl.
// The slave modport is the sequencer's view; master is the environment driving pixels.
interface che_hist_ctrl_if #(
  parameter int TX     = 4,
  parameter int DAT_WD = 8
);
  logic              pix_vld_i;
  logic              pix_sof_i;
  logic [DAT_WD-1:0] pix_dat_i;
  logic              map_rdy_i;

  logic              wr_en_o;
  logic [1:0]        wr_num_o;
  logic [TX-1:0]     wr_addr_o;
  logic [DAT_WD-1:0] dat_o;

  logic              rd_en_a_o;
  logic              rd_en_b_o;
  logic [1:0]        rd_num_a_o;
  logic [1:0]        rd_num_b_o;
  logic [TX-1:0]     rd_addr_a_o;
  logic [TX-1:0]     rd_addr_b_o;
  logic              rd_double_flg_a_o;
  logic              rd_double_flg_b_o;

  logic              cl_en_c_o;
  logic [1:0]        cl_num_c_o;
  logic              frm_done_o;
  logic              err_o;

  modport master (
    output pix_vld_i, pix_sof_i, pix_dat_i, map_rdy_i,
    input  wr_en_o, wr_num_o, wr_addr_o, dat_o,
    input  rd_en_a_o, rd_en_b_o, rd_num_a_o, rd_num_b_o,
    input  rd_addr_a_o, rd_addr_b_o, rd_double_flg_a_o, rd_double_flg_b_o,
    input  cl_en_c_o, cl_num_c_o, frm_done_o, err_o
  );

  modport slave (
    input  pix_vld_i, pix_sof_i, pix_dat_i, map_rdy_i,
    output wr_en_o, wr_num_o, wr_addr_o, dat_o,
    output rd_en_a_o, rd_en_b_o, rd_num_a_o, rd_num_b_o,
    output rd_addr_a_o, rd_addr_b_o, rd_double_flg_a_o, rd_double_flg_b_o,
    output cl_en_c_o, cl_num_c_o, frm_done_o, err_o
  );
endinterface

// File: rtl/che_hist_ctrl.sv
// CLAHE tile-histogram sequencer: raster writes into three rotating banks, paired tile-row reads, bank clears.
// Define CHE_HIST_CTRL_ERR_EN to build the sticky err_o register (otherwise err_o is tied low).
module che_hist_ctrl #(
  parameter int SIZ_X    = 32,
  parameter int SIZ_Y    = 32,
  parameter int TILE_SIZ = 8,
  parameter int DAT_WD   = 8
) (
  input  logic           clk,
  input  logic           rstn,
  che_hist_ctrl_if.slave bus
);
  localparam int TX  = SIZ_X / TILE_SIZ;
  localparam int TY  = SIZ_Y / TILE_SIZ;
  localparam int XW  = $clog2(SIZ_X);
  localparam int YW  = $clog2(SIZ_Y);
  localparam int TYW = $clog2(TY);
  localparam int CW  = (TX > 1) ? $clog2(TX) : 1;

  typedef enum logic [2:0] {IDLE, RD, CLR_UP, RD_BOT, CLR_BOT} state_t;

  function automatic logic [TX-1:0] oneHot(input int idx);
    return TX'(1) << idx;
  endfunction

  function automatic logic [1:0] prevBank(input logic [1:0] b);
    return (b == 2'd0) ? 2'd2 : b - 2'd1;
  endfunction

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [TYW-1:0]    r_ty;
  logic [1:0]        r_wb;
  logic              r_wrEn;
  logic [1:0]        r_wrNum;
  logic [TX-1:0]     r_wrAddr;
  logic [DAT_WD-1:0] r_dat;
  logic              r_trig;
  logic [1:0]        r_trigWb;
  logic              r_trigTop;
  logic              r_trigLast;
  state_t            r_state;
  logic [CW-1:0]     r_col;
  logic              r_rdEn;
  logic [1:0]        r_rdNumA;
  logic [1:0]        r_rdNumB;
  logic [TX-1:0]     r_rdAddr;
  logic              r_rdDbl;
  logic              r_pair;
  logic              r_last;
  logic              r_clEn;
  logic [1:0]        r_clNum;
  logic              r_frmDone;

  logic              w_sof;
  logic              w_abort;
  logic [XW-1:0]     w_x;
  logic [YW-1:0]     w_y;
  logic [TYW-1:0]    w_ty;
  logic [1:0]        w_wb;
  logic              w_lastX;
  logic              w_lastY;
  logic              w_lastTileLine;
  logic              w_trig;

  // A start-of-frame pixel is itself pixel (0,0) of tile row 0.
  assign w_sof          = bus.pix_vld_i & bus.pix_sof_i;
  assign w_x            = w_sof ? '0 : r_x;
  assign w_y            = w_sof ? '0 : r_y;
  assign w_ty           = w_sof ? '0 : r_ty;
  assign w_wb           = w_sof ? 2'd0 : r_wb;
  assign w_lastX        = (w_x == XW'(SIZ_X - 1));
  assign w_lastY        = (w_y == YW'(SIZ_Y - 1));
  assign w_lastTileLine = ((int'(w_y) % TILE_SIZ) == TILE_SIZ - 1);
  assign w_trig         = bus.pix_vld_i & w_lastX & w_lastTileLine;
  assign w_abort        = w_sof & ((r_state != IDLE) | (r_x != '0) | (r_y != '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x  <= '0;
      r_y  <= '0;
      r_ty <= '0;
      r_wb <= 2'd0;
    end else if (bus.pix_vld_i) begin
      r_x  <= w_lastX ? '0 : w_x + 1'b1;
      r_y  <= w_y;
      r_ty <= w_ty;
      r_wb <= w_wb;
      if (w_lastX && w_lastY) begin
        r_y  <= '0;
        r_ty <= '0;
        r_wb <= 2'd0;
      end else if (w_lastX) begin
        r_y <= w_y + 1'b1;
        if (w_lastTileLine) begin
          r_ty <= w_ty + 1'b1;
          r_wb <= (w_wb == 2'd2) ? 2'd0 : w_wb + 2'd1;
        end
      end
    end
  end

  // Write path and trigger capture; the trigger also snapshots which tile row just finished.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrEn     <= 1'b0;
      r_wrNum    <= 2'd0;
      r_wrAddr   <= '0;
      r_dat      <= '0;
      r_trig     <= 1'b0;
      r_trigWb   <= 2'd0;
      r_trigTop  <= 1'b0;
      r_trigLast <= 1'b0;
    end else begin
      r_wrEn <= bus.pix_vld_i;
      r_trig <= w_trig;
      if (bus.pix_vld_i) begin
        r_wrNum    <= w_wb;
        r_wrAddr   <= oneHot(int'(w_x) / TILE_SIZ);
        r_dat      <= bus.pix_dat_i;
        r_trigWb   <= w_wb;
        r_trigTop  <= (w_ty == '0);
        r_trigLast <= (w_ty == TYW'(TY - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_rdEn    <= 1'b0;
      r_rdNumA  <= 2'd0;
      r_rdNumB  <= 2'd0;
      r_rdAddr  <= '0;
      r_rdDbl   <= 1'b0;
      r_pair    <= 1'b0;
      r_last    <= 1'b0;
      r_clEn    <= 1'b0;
      r_clNum   <= 2'd0;
      r_frmDone <= 1'b0;
    end else begin
      r_frmDone <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_rdEn  <= 1'b0;
        r_clEn  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (r_trig) begin
            r_state  <= RD;
            r_col    <= '0;
            r_rdEn   <= 1'b1;
            r_rdAddr <= oneHot(0);
            r_rdDbl  <= (TX > 1);
            r_rdNumA <= r_trigTop ? r_trigWb : prevBank(r_trigWb);
            r_rdNumB <= r_trigWb;
            r_pair   <= !r_trigTop;
            r_last   <= r_trigLast;
          end
          RD, RD_BOT: if (bus.map_rdy_i) begin
            if (r_col == CW'(TX - 1)) begin
              r_rdEn <= 1'b0;
              if (r_state == RD_BOT) begin
                r_state <= CLR_BOT;
                r_clEn  <= 1'b1;
                r_clNum <= r_rdNumB;
              end else if (r_pair) begin
                r_state <= CLR_UP;
                r_clEn  <= 1'b1;
                r_clNum <= r_rdNumA;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_col    <= r_col + 1'b1;
              r_rdAddr <= oneHot(int'(r_col) + 1);
              r_rdDbl  <= (int'(r_col) + 1 < TX - 1);
            end
          end
          // Bottom edge re-reads the last written bank on both ports.
          CLR_UP: begin
            r_clEn <= 1'b0;
            if (r_last) begin
              r_state  <= RD_BOT;
              r_col    <= '0;
              r_rdEn   <= 1'b1;
              r_rdAddr <= oneHot(0);
              r_rdDbl  <= (TX > 1);
              r_rdNumA <= r_rdNumB;
            end else begin
              r_state <= IDLE;
            end
          end
          CLR_BOT: begin
            r_clEn    <= 1'b0;
            r_frmDone <= 1'b1;
            r_state   <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef CHE_HIST_CTRL_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_abort || (r_trig && (r_state != IDLE))) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.wr_en_o           = r_wrEn;
  assign bus.wr_num_o          = r_wrNum;
  assign bus.wr_addr_o         = r_wrAddr;
  assign bus.dat_o             = r_dat;
  assign bus.rd_en_a_o         = r_rdEn;
  assign bus.rd_en_b_o         = r_rdEn;
  assign bus.rd_num_a_o        = r_rdNumA;
  assign bus.rd_num_b_o        = r_rdNumB;
  assign bus.rd_addr_a_o       = r_rdAddr;
  assign bus.rd_addr_b_o       = r_rdAddr;
  assign bus.rd_double_flg_a_o = r_rdDbl;
  assign bus.rd_double_flg_b_o = r_rdDbl;
  assign bus.cl_en_c_o         = r_clEn;
  assign bus.cl_num_c_o        = r_clNum;
  assign bus.frm_done_o        = r_frmDone;
endmodule

// File: tb/tb_che_hist_ctrl.sv
// Directed bench for che_hist_ctrl at 32x32 frame, 8x8 tiles (TX = TY = 4).
// Expected err_o follows CHE_HIST_CTRL_ERR_EN.
module tb_che_hist_ctrl;
`ifdef CHE_HIST_CTRL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [1:0] na;
    logic [1:0] nb;
    logic [3:0] aa;
    logic [3:0] ab;
    logic       da;
    logic       db;
  } rdRec_t;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  int   cyc;
  int   enSplit;
  int   frmDoneCnt;
  int   frmDoneCyc;
  int   lastClCyc;
  rdRec_t     rdLog[$];
  logic [1:0] clLog[$];
  logic [1:0] frmClLog[$];

  che_hist_ctrl_if #(.TX(4), .DAT_WD(8)) bus ();

  che_hist_ctrl #(.SIZ_X(32), .SIZ_Y(32), .TILE_SIZ(8), .DAT_WD(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Outputs are logged at the falling edge, away from where the DUT updates.
  always @(negedge clk) begin
    cyc++;
    if (bus.rd_en_a_o != bus.rd_en_b_o) enSplit++;
    if (bus.rd_en_a_o && bus.map_rdy_i)
      rdLog.push_back('{bus.rd_num_a_o, bus.rd_num_b_o, bus.rd_addr_a_o, bus.rd_addr_b_o,
                        bus.rd_double_flg_a_o, bus.rd_double_flg_b_o});
    if (bus.cl_en_c_o) begin
      clLog.push_back(bus.cl_num_c_o);
      frmClLog.push_back(bus.cl_num_c_o);
      lastClCyc = cyc;
    end
    if (bus.frm_done_o) begin
      frmDoneCnt++;
      frmDoneCyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic sof, input logic [7:0] dat);
    bus.pix_vld_i = vld;
    bus.pix_sof_i = sof;
    bus.pix_dat_i = dat;
    tick();
  endtask

  task automatic idle(input int n);
    bus.pix_vld_i = 1'b0;
    bus.pix_sof_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic streamRows(input int y0, input int y1, input bit withSof);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < 32; x++) begin
        logic [7:0] d;
        d = (x == 13 && y == 17) ? 8'h5A : 8'(x + 3 * y);
        applyStimulus(1'b1, withSof && (y == y0) && (x == 0), d);
        if (x == 13 && y == 17) begin
          checkOutput("wr_en(13,17)", 32'(bus.wr_en_o), 32'd1);
          checkOutput("wr_num(13,17)", 32'(bus.wr_num_o), 32'd2);
          checkOutput("wr_addr(13,17)", 32'(bus.wr_addr_o), 32'b0010);
          checkOutput("dat(13,17)", 32'(bus.dat_o), 32'h5A);
        end
      end
    end
  endtask

  task automatic clearLogs();
    rdLog.delete();
    clLog.delete();
  endtask

  // Four accepted reads from log index base: columns 0..3, double flag low only on the last.
  task automatic checkReadSeq(input string tag, input int base, input logic [1:0] na, input logic [1:0] nb);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << i;
      if (rdLog.size() > base + i) begin
        checkOutput({tag, "_numA"}, 32'(rdLog[base+i].na), 32'(na));
        checkOutput({tag, "_numB"}, 32'(rdLog[base+i].nb), 32'(nb));
        checkOutput({tag, "_addrA"}, 32'(rdLog[base+i].aa), 32'(oh));
        checkOutput({tag, "_addrB"}, 32'(rdLog[base+i].ab), 32'(oh));
        checkOutput({tag, "_dblA"}, 32'(rdLog[base+i].da), (i < 3) ? 32'd1 : 32'd0);
        checkOutput({tag, "_dblB"}, 32'(rdLog[base+i].db), (i < 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rstn = 1'b1;
    checks = 0;
    failures = 0;
    cyc = 0;
    enSplit = 0;
    frmDoneCnt = 0;
    frmDoneCyc = -1;
    lastClCyc = -1;
    bus.pix_vld_i = 1'b0;
    bus.pix_sof_i = 1'b0;
    bus.pix_dat_i = 8'h00;
    bus.map_rdy_i = 1'b1;

    #3 rstn = 1'b0;
    #1;
    checkOutput("rst_wr_en", 32'(bus.wr_en_o), 32'd0);
    checkOutput("rst_rd_en", 32'(bus.rd_en_a_o), 32'd0);
    checkOutput("rst_cl_en", 32'(bus.cl_en_c_o), 32'd0);
    checkOutput("rst_frm_done", 32'(bus.frm_done_o), 32'd0);
    checkOutput("rst_err", 32'(bus.err_o), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    $display("[TB] top edge");
    clearLogs();
    frmClLog.delete();
    streamRows(0, 7, 1'b1);
    checkOutput("trig_no_early_rd", 32'(bus.rd_en_a_o), 32'd0);
    idle(1);
    checkOutput("first_rd_en", 32'(bus.rd_en_a_o), 32'd1);
    checkOutput("first_rd_addr", 32'(bus.rd_addr_a_o), 32'b0001);
    idle(10);
    checkOutput("top_reads", 32'(rdLog.size()), 32'd4);
    checkReadSeq("top", 0, 2'd0, 2'd0);
    checkOutput("top_no_clear", 32'(clLog.size()), 32'd0);

    $display("[TB] pair with backpressure");
    clearLogs();
    streamRows(8, 15, 1'b0);
    idle(1);
    checkOutput("bp_c0_addr", 32'(bus.rd_addr_a_o), 32'b0001);
    tick();
    bus.map_rdy_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_hold_en", 32'(bus.rd_en_a_o), 32'd1);
      checkOutput("bp_hold_addr", 32'(bus.rd_addr_a_o), 32'b0010);
      if (k < 3) tick();
    end
    bus.map_rdy_i = 1'b1;
    idle(10);
    checkOutput("bp_reads", 32'(rdLog.size()), 32'd4);
    checkReadSeq("bp", 0, 2'd0, 2'd1);
    checkOutput("bp_clear_cnt", 32'(clLog.size()), 32'd1);
    if (clLog.size() > 0) checkOutput("bp_clear_num", 32'(clLog[0]), 32'd0);

    $display("[TB] write mapping and row 23");
    clearLogs();
    streamRows(16, 23, 1'b0);
    idle(10);
    checkOutput("r23_reads", 32'(rdLog.size()), 32'd4);
    checkReadSeq("r23", 0, 2'd1, 2'd2);
    checkOutput("r23_clear_cnt", 32'(clLog.size()), 32'd1);
    if (clLog.size() > 0) checkOutput("r23_clear_num", 32'(clLog[0]), 32'd1);

    $display("[TB] frame end");
    clearLogs();
    streamRows(24, 31, 1'b0);
    idle(20);
    checkOutput("end_reads", 32'(rdLog.size()), 32'd8);
    checkReadSeq("end_pair", 0, 2'd2, 2'd0);
    checkReadSeq("end_bot", 4, 2'd0, 2'd0);
    checkOutput("end_clear_cnt", 32'(clLog.size()), 32'd2);
    if (clLog.size() > 1) begin
      checkOutput("end_clear0", 32'(clLog[0]), 32'd2);
      checkOutput("end_clear1", 32'(clLog[1]), 32'd0);
    end
    checkOutput("frm_clear_cnt", 32'(frmClLog.size()), 32'd4);
    if (frmClLog.size() > 3) begin
      checkOutput("frm_clear0", 32'(frmClLog[0]), 32'd0);
      checkOutput("frm_clear1", 32'(frmClLog[1]), 32'd1);
      checkOutput("frm_clear2", 32'(frmClLog[2]), 32'd2);
      checkOutput("frm_clear3", 32'(frmClLog[3]), 32'd0);
    end
    checkOutput("frm_done_cnt", 32'(frmDoneCnt), 32'd1);
    checkOutput("frm_done_timing", 32'(frmDoneCyc), 32'(lastClCyc + 1));
    checkOutput("frm_no_err", 32'(bus.err_o), 32'd0);

    $display("[TB] overflow");
    clearLogs();
    streamRows(0, 6, 1'b1);
    bus.map_rdy_i = 1'b0;
    streamRows(7, 14, 1'b0);
    checkOutput("ovf_err_before", 32'(bus.err_o), 32'd0);
    checkOutput("ovf_stuck_en", 32'(bus.rd_en_a_o), 32'd1);
    streamRows(15, 15, 1'b0);
    idle(1);
    checkOutput("ovf_err", 32'(bus.err_o), 32'(ERR_EXP));
    checkOutput("ovf_stuck_addr", 32'(bus.rd_addr_a_o), 32'b0001);
    checkOutput("ovf_stuck_numB", 32'(bus.rd_num_b_o), 32'd0);
    bus.map_rdy_i = 1'b1;
    idle(10);
    checkOutput("ovf_reads", 32'(rdLog.size()), 32'd4);
    checkReadSeq("ovf", 0, 2'd0, 2'd0);
    checkOutput("ovf_no_clear", 32'(clLog.size()), 32'd0);

    $display("[TB] abort");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    checkOutput("abort_pre_err", 32'(bus.err_o), 32'd0);
    streamRows(0, 6, 1'b1);
    bus.map_rdy_i = 1'b0;
    streamRows(7, 8, 1'b0);
    for (int x = 0; x < 5; x++) applyStimulus(1'b1, 1'b0, 8'(x));
    clearLogs();
    applyStimulus(1'b1, 1'b1, 8'h33);
    checkOutput("abort_wr_num", 32'(bus.wr_num_o), 32'd0);
    checkOutput("abort_wr_addr", 32'(bus.wr_addr_o), 32'b0001);
    checkOutput("abort_dat", 32'(bus.dat_o), 32'h33);
    checkOutput("abort_rd_en_a", 32'(bus.rd_en_a_o), 32'd0);
    checkOutput("abort_rd_en_b", 32'(bus.rd_en_b_o), 32'd0);
    checkOutput("abort_err", 32'(bus.err_o), 32'(ERR_EXP));
    bus.map_rdy_i = 1'b1;
    for (int x = 1; x <= 9; x++) applyStimulus(1'b1, 1'b0, 8'(x));
    checkOutput("abort_post_num", 32'(bus.wr_num_o), 32'd0);
    checkOutput("abort_post_addr", 32'(bus.wr_addr_o), 32'b0010);
    idle(5);
    checkOutput("abort_no_reads", 32'(rdLog.size()), 32'd0);
    rstn = 1'b0;
    #1;
    checkOutput("rst2_wr_en", 32'(bus.wr_en_o), 32'd0);
    checkOutput("rst2_wr_num", 32'(bus.wr_num_o), 32'd0);
    checkOutput("rst2_wr_addr", 32'(bus.wr_addr_o), 32'd0);
    checkOutput("rst2_dat", 32'(bus.dat_o), 32'd0);
    checkOutput("rst2_rd_en", 32'(bus.rd_en_a_o), 32'd0);
    checkOutput("rst2_cl_en", 32'(bus.cl_en_c_o), 32'd0);
    checkOutput("rst2_frm_done", 32'(bus.frm_done_o), 32'd0);
    checkOutput("rst2_err", 32'(bus.err_o), 32'd0);
    checkOutput("rdEnPaired", 32'(enSplit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/che_hist_ctrl.md
# che_hist_ctrl

Sequencer that drives the three-bank CLAHE tile-histogram store from the pixel side. It turns a raster pixel stream into per-tile histogram writes and rotates the write target across banks 0/1/2 by tile row. Once each tile row completes, it issues paired upper/lower tile-row reads toward the mapping stage, then clears banks that are no longer needed. It connects directly to the store's write, read-A, read-B and clear ports.

## Interface
Parameters:
- SIZ_X, 32: frame width in pixels; multiple of TILE_SIZ.
- SIZ_Y, 32: frame height in pixels; multiple of TILE_SIZ; SIZ_Y/TILE_SIZ ≥ 2.
- TILE_SIZ, 8: tile edge in pixels.
- DAT_WD, 8: pixel width.
- Derived: TX = SIZ_X/TILE_SIZ, TY = SIZ_Y/TILE_SIZ.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- pix_vld_i  in  1  pixel valid.
- pix_sof_i  in  1  first pixel of frame; qualified by pix_vld_i.
- pix_dat_i  in  DAT_WD  pixel value.
- map_rdy_i  in  1  mapping stage accepts the current read.
- wr_en_o  out  1  histogram write strobe.
- wr_num_o  out  2  write bank, 0..2.
- wr_addr_o  out  TX  one-hot tile column.
- dat_o  out  DAT_WD  pixel to bin.
- rd_en_a_o, rd_en_b_o  out  1  upper (A) and lower (B) read strobes.
- rd_num_a_o, rd_num_b_o  out  2  bank to read.
- rd_addr_a_o, rd_addr_b_o  out  TX  one-hot left tile column.
- rd_double_flg_a_o, rd_double_flg_b_o  out  1  also read the right neighbour (column c+1).
- cl_en_c_o  out  1  one-cycle bank clear strobe.
- cl_num_c_o  out  2  bank to clear.
- frm_done_o  out  1  one-cycle pulse; the frame's final clear has issued.
- err_o  out  1  sticky error (see Configuration).

## Operation
- Counters: x runs 0..SIZ_X-1 and y runs 0..SIZ_Y-1. Both advance on pix_vld_i and wrap at end of line and end of frame. pix_sof_i forces x=0, y=0, and tile row ty=0.
- Write bank: wb = ty mod 3, implemented as a 0→1→2→0 counter that steps when y crosses a tile boundary.
- Write path, registered: wr_en_o=pix_vld_i, wr_num_o=wb, wr_addr_o=onehot(x/TILE_SIZ), dat_o=pix_dat_i.
- Trigger: the last pixel of tile row ty, i.e. x=SIZ_X-1 and y%TILE_SIZ=TILE_SIZ-1, starts a read phase. The trigger depends on ty:
  - ty=0: top edge. A and B both read bank 0. No clear.
  - 0<ty<TY-1: pair. A reads bank (ty-1) mod 3, B reads bank ty mod 3. Then bank (ty-1) mod 3 is cleared.
  - ty=TY-1: pair as above, then bottom edge (A and B both read bank ty mod 3), then that bank is cleared, then frm_done_o pulses.
- FSM states:
  - IDLE: waits for a trigger.
  - RD: issues reads.
  - CLR_UP: clears the upper bank.
  - RD_BOT: issues bottom-edge reads.
  - CLR_BOT: clears the final bank.
  - Transitions: IDLE→RD on trigger. RD→CLR_UP after the last column is accepted (pair), or RD→IDLE (top edge). CLR_UP→IDLE, or CLR_UP→RD_BOT if it was the last row. RD_BOT→CLR_BOT after the last column. CLR_BOT→IDLE, pulsing frm_done_o.
- Read sequence: column c = 0..TX-1, one per accepted cycle.
  - rd_addr_*=onehot(c).
  - rd_double_flg_* = 1 for c<TX-1, and 0 at c=TX-1.
- Read handshake:
  - rd_en_a_o and rd_en_b_o are asserted together.
  - c advances only in a cycle where map_rdy_i=1.
  - While map_rdy_i=0, all read outputs hold.
  - Reads never retract.
- Clear: cl_en_c_o is high for exactly one cycle, in the cycle after the last accepted read.
- Writes continue in parallel with read and clear phases. Three banks guarantee the bank being written is never the bank being read or cleared.
- Trigger while FSM≠IDLE: the trigger is dropped and err_o is set.
- pix_sof_i while FSM≠IDLE or (x,y)≠(0,0):
  - FSM→IDLE and all read/clear outputs go low next cycle.
  - err_o is set.
  - Bank contents are undefined until reset.
- Reset: all outputs are 0, counters are 0, wb=0, FSM=IDLE.

## Timing
- Write latency: 1 cycle from the pix_vld_i edge to wr_en_o.
- First read strobe: 2 cycles after the triggering pixel (1 cycle register plus 1 cycle FSM entry).
- Minimum read-phase length: TX cycles at map_rdy_i=1. A pair phase adds 1 clear cycle; the last row adds TX+1 more cycles.
- Budget: a phase must end within SIZ_X·TILE_SIZ valid pixels (one tile row). Exceeding it produces the dropped-trigger error.
- frm_done_o fires in the cycle after the CLR_BOT clear strobe.

## Configuration
- CHE_HIST_CTRL_ERR_EN defined:
  - err_o is a sticky register.
  - Set on a dropped trigger or an illegal pix_sof_i.
  - Cleared only by rstn.
- Undefined:
  - err_o is tied to 0 and no error logic is built.
  - Dropped-trigger and sof-abort behaviour is unchanged.

## Test plan
All scenarios use SIZ_X=SIZ_Y=32, TILE_SIZ=8, so TX=TY=4.
- Write mapping: pixel (x=13, y=17), pix_dat_i=0x5A → next cycle wr_en_o=1, wr_num_o=2, wr_addr_o=4'b0010, dat_o=0x5A.
- Top edge: full rows 0..7 with map_rdy_i=1 → 4 reads, a=b=bank0, addr 0001/0010/0100/1000, double 1,1,1,0; no cl_en_c_o.
- Pair with backpressure: row 15 ends; map_rdy_i=0 for 3 cycles on c=1 → outputs hold c=1 for 4 cycles; A=bank0, B=bank1; then cl_en_c_o=1 with cl_num_c_o=0 for 1 cycle.
- Frame end: row 31 ends → pair reads (A=2, B=0), clear 2, bottom reads (A=B=0), clear 0, frm_done_o one pulse; over the frame, cl_num values seen are exactly {0,1,2,0}.
- Overflow: hold map_rdy_i=0 from the row-7 trigger through the row-15 trigger → the row-15 trigger is dropped; err_o=1 with the macro, err_o=0 without.
- Abort: pix_sof_i at (x=5, y=9) mid-frame → counters reset, FSM=IDLE, err_o=1 (with macro); rstn low → all outputs 0, err_o=0.
